age_ordered_reservation_station: RTL and testbench



---
 rtl/age_ordered_reservation_station.sv | 167 ++++++++++++++++
 tb/tb_age_ordered_reservation_station.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/age_ordered_reservation_station.sv
// Age-ordered reservation station: free-list slots, an age matrix for oldest-ready-first
// selection, multi-channel wakeup with dispatch bypass, and a ready/valid issue register.
module age_ordered_reservation_station #(
    parameter  int NUM_ENTRIES = 16,
    parameter  int NUM_CDB     = 4,
    parameter  int ROB_TAG_LEN = 6,
    parameter  int XLEN        = 32,
    localparam int IDX_W       = $clog2(NUM_ENTRIES),
    localparam int CNT_W       = $clog2(NUM_ENTRIES + 1),
    localparam int INST_RS     = 2 * XLEN + 3 * ROB_TAG_LEN + 2
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      flush,
    input  logic                                      load,
    input  logic [INST_RS-1:0]                        insn_load,
    input  logic [NUM_CDB-1:0]                        wakeup,
    input  logic [NUM_CDB-1:0][ROB_TAG_LEN-1:0]       wakeup_tag,
    input  logic [NUM_CDB-1:0][XLEN-1:0]              wakeup_value,
    output logic                                      issue_valid,
    output logic [INST_RS-1:0]                        issue_insn,
    input  logic                                      issue_ready,
    output logic                                      is_full,
    output logic [CNT_W-1:0]                          free_count
);

    // Payload layout from LSB: value_src2, ready_src2, tag_src2, value_src1, ready_src1, tag_src1, dest tag.
    localparam int V2_LO = 0;
    localparam int R2    = XLEN;
    localparam int T2_LO = XLEN + 1;
    localparam int V1_LO = XLEN + 1 + ROB_TAG_LEN;
    localparam int R1    = 2 * XLEN + 1 + ROB_TAG_LEN;
    localparam int T1_LO = 2 * XLEN + 2 + ROB_TAG_LEN;

    logic [NUM_ENTRIES-1:0] valid_r;
    logic [INST_RS-1:0]     payload_r [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] age_r     [NUM_ENTRIES];
    logic                   issue_valid_r;
    logic [INST_RS-1:0]     issue_insn_r;
    logic [CNT_W-1:0]       count_r;

    logic [IDX_W-1:0]       free_idx_s;
    logic [IDX_W-1:0]       sel_idx_s;
    logic [NUM_ENTRIES-1:0] cand_s;
    logic [NUM_ENTRIES-1:0] oldest_s;
    logic                   any_cand_s;
    logic                   accept_s;
    logic                   advance_s;
    logic                   fire_s;

    // Descending loop so the lowest matching channel is the final writer.
    function automatic logic [INST_RS-1:0] wake_insn(
        input logic [INST_RS-1:0]                  insn,
        input logic [NUM_CDB-1:0]                  wv,
        input logic [NUM_CDB-1:0][ROB_TAG_LEN-1:0] wt,
        input logic [NUM_CDB-1:0][XLEN-1:0]        wval
    );
        logic [INST_RS-1:0] res;
        res = insn;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (!insn[R1] && wv[c] && (wt[c] == insn[T1_LO +: ROB_TAG_LEN])) begin
                res[R1]             = 1'b1;
                res[V1_LO +: XLEN]  = wval[c];
            end else begin
                res[R1]             = res[R1];
            end
            if (!insn[R2] && wv[c] && (wt[c] == insn[T2_LO +: ROB_TAG_LEN])) begin
                res[R2]             = 1'b1;
                res[V2_LO +: XLEN]  = wval[c];
            end else begin
                res[R2]             = res[R2];
            end
        end
        return res;
    endfunction

    // Lowest free slot, candidate set, and the single oldest candidate.
    always_comb begin
        free_idx_s = '0;
        sel_idx_s  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cand_s[i] = valid_r[i] & payload_r[i][R1] & payload_r[i][R2];
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            oldest_s[i] = cand_s[i] & ~(|(age_r[i] & cand_s));
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
            if (oldest_s[i]) begin
                sel_idx_s = IDX_W'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
        any_cand_s = |cand_s;
        accept_s   = load && !is_full && !flush;
        advance_s  = !issue_valid_r || issue_ready;
        fire_s     = advance_s && any_cand_s && !flush;
    end

    // Slot valid bits, payload capture/wakeup, and age matrix maintenance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_r <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                payload_r[i] <= '0;
                age_r[i]     <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (accept_s && (free_idx_s == IDX_W'(i))) begin
                    valid_r[i]   <= 1'b1;
                    payload_r[i] <= wake_insn(insn_load, wakeup, wakeup_tag, wakeup_value);
                    age_r[i]     <= valid_r;
                end else begin
                    if (fire_s && (sel_idx_s == IDX_W'(i))) begin
                        valid_r[i] <= 1'b0;
                    end else if (valid_r[i]) begin
                        payload_r[i] <= wake_insn(payload_r[i], wakeup, wakeup_tag, wakeup_value);
                    end
                    // A newly dispatched slot is younger than everyone.
                    if (accept_s) begin
                        age_r[i][free_idx_s] <= 1'b0;
                    end
                end
            end
        end
    end

    // Issue register: refills whenever empty or accepted, holds stable under backpressure.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            issue_valid_r <= 1'b0;
            issue_insn_r  <= '0;
        end else if (flush) begin
            issue_valid_r <= 1'b0;
        end else if (advance_s) begin
            issue_valid_r <= any_cand_s;
            if (any_cand_s) begin
                issue_insn_r <= payload_r[sel_idx_s];
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (flush) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(accept_s) - CNT_W'(fire_s);
        end
    end

    assign issue_valid = issue_valid_r;
    assign issue_insn  = issue_insn_r;
    assign is_full     = (count_r == CNT_W'(NUM_ENTRIES));
    assign free_count  = CNT_W'(NUM_ENTRIES) - count_r;

endmodule

// File: tb/tb_age_ordered_reservation_station.sv
// Randomized and directed bench for age_ordered_reservation_station against an
// age-ordered queue model of the station.
module tb_age_ordered_reservation_station;

    localparam int N  = 16;
    localparam int C  = 4;
    localparam int TW = 6;
    localparam int XW = 32;
    localparam int IW = 2 * XW + 3 * TW + 2;
    localparam int CW = $clog2(N + 1);

    typedef struct packed {
        logic [TW-1:0] dest;
        logic [TW-1:0] t1;
        logic          r1;
        logic [XW-1:0] v1;
        logic [TW-1:0] t2;
        logic          r2;
        logic [XW-1:0] v2;
    } insn_t;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     flush;
    logic                     load;
    logic [IW-1:0]            insn_load;
    logic [C-1:0]             wakeup;
    logic [C-1:0][TW-1:0]     wakeup_tag;
    logic [C-1:0][XW-1:0]     wakeup_value;
    logic                     issue_valid;
    logic [IW-1:0]            issue_insn;
    logic                     issue_ready;
    logic                     is_full;
    logic [CW-1:0]            free_count;

    age_ordered_reservation_station #(
        .NUM_ENTRIES(N), .NUM_CDB(C), .ROB_TAG_LEN(TW), .XLEN(XW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .load(load), .insn_load(insn_load),
        .wakeup(wakeup), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
        .issue_valid(issue_valid), .issue_insn(issue_insn), .issue_ready(issue_ready),
        .is_full(is_full), .free_count(free_count)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    insn_t q[$];
    insn_t issued[$];
    logic  m_iv;
    insn_t m_insn;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic insn_t mk(input int dest, input int t1, input bit r1, input int v1,
                                 input int t2, input bit r2, input int v2);
        insn_t x;
        x.dest = TW'(dest); x.t1 = TW'(t1); x.r1 = r1; x.v1 = XW'(v1);
        x.t2 = TW'(t2); x.r2 = r2; x.v2 = XW'(v2);
        return x;
    endfunction

    // First active channel (lowest index) that matches a waiting source supplies it.
    function automatic insn_t wake(input insn_t x);
        insn_t y;
        y = x;
        for (int c = 0; c < C; c++) begin
            if (!y.r1 && wakeup[c] && wakeup_tag[c] == y.t1) begin
                y.r1 = 1'b1; y.v1 = wakeup_value[c];
            end
            if (!y.r2 && wakeup[c] && wakeup_tag[c] == y.t2) begin
                y.r2 = 1'b1; y.v2 = wakeup_value[c];
            end
        end
        return y;
    endfunction

    task automatic idle();
        load = 1'b0; flush = 1'b0; wakeup = '0; insn_load = '0;
    endtask

    task automatic step();
        bit   full;
        bit   adv;
        int   idx;
        if (reset_n && !flush && issue_valid && issue_ready) issued.push_back(insn_t'(issue_insn));
        @(posedge clk);
        if (!reset_n) begin
            q.delete(); m_iv = 1'b0; m_insn = '0;
        end else if (flush) begin
            q.delete(); m_iv = 1'b0;
        end else begin
            full = (q.size() == N);
            adv  = !m_iv || issue_ready;
            idx  = -1;
            for (int k = 0; k < q.size(); k++) begin
                if (idx < 0 && q[k].r1 && q[k].r2) idx = k;
            end
            if (adv) begin
                if (idx >= 0) begin
                    m_insn = q[idx]; m_iv = 1'b1; q.delete(idx);
                end else begin
                    m_iv = 1'b0;
                end
            end
            for (int k = 0; k < q.size(); k++) q[k] = wake(q[k]);
            if (load && !full) q.push_back(wake(insn_t'(insn_load)));
        end
        #1;
        check_eq("issue_valid", issue_valid, m_iv);
        check_eq("issue_insn", issue_insn, m_insn);
        check_eq("is_full", is_full, q.size() == N);
        check_eq("free_count", free_count, N - q.size());
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int base;
        insn_t x;
        reset_n = 1'b0; issue_ready = 1'b0; wakeup_tag = '0; wakeup_value = '0;
        m_iv = 1'b0; m_insn = '0;
        idle();
        steps(2);
        reset_n = 1'b1;
        steps(10);
        check_eq("rst_free_count", free_count, N);
        check_eq("rst_issue_valid", issue_valid, 1'b0);

        // Age order: B ready first, then A before C after a wakeup on channel 2.
        issue_ready = 1'b1;
        base = issued.size();
        load = 1'b1; insn_load = mk(3, 9, 0, 0, 1, 1, 11); step();
        insn_load = mk(4, 1, 1, 22, 1, 1, 33); step();
        insn_load = mk(5, 9, 0, 0, 2, 1, 44); step();
        idle(); steps(2);
        wakeup[2] = 1'b1; wakeup_tag[2] = 6'd9; wakeup_value[2] = 32'hDEAD; step();
        idle(); steps(6);
        check_eq("age_count", issued.size() - base, 3);
        x = issued[base];     check_eq("age_first_B", x.dest, 4);
        x = issued[base + 1]; check_eq("age_second_A", x.dest, 3);
        check_eq("age_A_val", x.v1, 32'hDEAD);
        x = issued[base + 2]; check_eq("age_third_C", x.dest, 5);
        check_eq("age_C_val", x.v1, 32'hDEAD);

        // Bypass on dispatch from channel 0.
        load = 1'b1; insn_load = mk(8, 7, 0, 0, 2, 1, 5);
        wakeup[0] = 1'b1; wakeup_tag[0] = 6'd7; wakeup_value[0] = 32'h55; step();
        idle(); steps(4);
        x = issued[$];
        check_eq("byp_dest", x.dest, 8);
        check_eq("byp_ready", x.r1, 1'b1);
        check_eq("byp_val", x.v1, 32'h55);

        // Backpressure: one entry parks in the issue register, 16 fill the slots, the rest drop.
        issue_ready = 1'b0;
        base = issued.size();
        for (int k = 0; k < 18; k++) begin
            load = 1'b1; insn_load = mk(k, 0, 1, k, 0, 1, k); step();
        end
        idle();
        check_eq("bp_full", is_full, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step();
            x = insn_t'(issue_insn);
            check_eq("bp_stable", x.dest, 0);
        end
        issue_ready = 1'b1;
        steps(22);
        check_eq("bp_count", issued.size() - base, 17);
        for (int k = 0; k < 17; k++) begin
            x = issued[base + k];
            check_eq("bp_order", x.dest, k);
        end

        // Flush collides with load and wakeup while entries are pending.
        issue_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            load = 1'b1; insn_load = mk(20 + k, 0, 1, 0, 0, 1, 0); step();
        end
        idle(); steps(2);
        check_eq("fl_pre_valid", issue_valid, 1'b1);
        base = issued.size();
        flush = 1'b1; load = 1'b1; insn_load = mk(30, 0, 1, 0, 0, 1, 0);
        wakeup[1] = 1'b1; wakeup_tag[1] = 6'd3; step();
        idle();
        check_eq("fl_free_count", free_count, N);
        check_eq("fl_issue_valid", issue_valid, 1'b0);
        issue_ready = 1'b1; steps(6);
        check_eq("fl_no_issue", issued.size() - base, 0);

        // Random traffic with occasional flush and one mid-run reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            load = ($urandom_range(0, 99) < 55);
            insn_load = mk($urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 1),
                           $urandom, $urandom_range(0, 7), $urandom_range(0, 1), $urandom);
            for (int c = 0; c < C; c++) begin
                wakeup[c]       = ($urandom_range(0, 99) < 25);
                wakeup_tag[c]   = TW'($urandom_range(0, 7));
                wakeup_value[c] = $urandom;
            end
            issue_ready = ($urandom_range(0, 99) < 60);
            flush       = ($urandom_range(0, 999) < 8);
            reset_n     = !(cyc >= 1500 && cyc < 1502);
            step();
        end
        reset_n = 1'b1;
        idle();
        steps(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
